// File: rtl/pulse_handshake_tx.sv
// pulse_handshake_tx
// Sends single-cycle events from the clk_dst domain to a far domain with a
// four-phase req/ack handshake. The returning ack_in level is resynchronised
// through SYNC_STAGES flops before the FSM uses it.
//
// Build option: define PULSE_HANDSHAKE_TX_QUEUE_EN to build the pending-event
// counter. The counter holds events that arrive while a handshake is in
// flight and saturates rather than wrapping. Without the macro, pending is
// tied to zero and any event that arrives while busy is dropped.
//
// SYNC_STAGES legal range is 2..4.
module pulse_handshake_tx #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic             clk_dst,
    input  logic             reset_n,
    input  logic             pulse_in,
    input  logic             ack_in,
    output logic             req_out,
    output logic             busy,
    output logic             drop,
    output logic [CNT_W-1:0] pending
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        REQ_LO = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;
    logic                   launch;
    logic                   drop_nxt;

    assign ack_s = ack_sync[SYNC_STAGES-1];
    assign busy  = (state != IDLE);

    // Resynchronise the far-domain acknowledge level
    always_ff @(posedge clk_dst or negedge reset_n) begin
        if (!reset_n) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_in};
        end
    end

`ifdef PULSE_HANDSHAKE_TX_QUEUE_EN
    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    logic             from_pend;
    logic             take_pulse;
    logic             queue_pulse;
    logic [CNT_W-1:0] pending_nxt;

    // Launch arbitration and pending-counter update; queued events win over
    // a new pulse, and a pulse that is not launched goes into the queue
    always_comb begin
        pending_nxt = pending;
        drop_nxt    = 1'b0;
        from_pend   = (state == IDLE) && (pending != '0);
        take_pulse  = (state == IDLE) && (pending == '0) && pulse_in;
        launch      = from_pend || take_pulse;
        queue_pulse = pulse_in && !take_pulse;
        if (queue_pulse && from_pend) begin
            // one slot freed by the launch, one taken by the new pulse
            pending_nxt = pending;
        end else if (queue_pulse) begin
            if (pending == PEND_MAX) begin
                drop_nxt = 1'b1;
            end else begin
                pending_nxt = pending + CNT_W'(1);
            end
        end else if (from_pend) begin
            pending_nxt = pending - CNT_W'(1);
        end
    end

    // Pending-event counter
    always_ff @(posedge clk_dst or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end
`else
    // Without a queue, only a pulse in IDLE launches; anything else is lost
    always_comb begin
        launch   = (state == IDLE) && pulse_in;
        drop_nxt = pulse_in && (state != IDLE);
    end

    assign pending = '0;
`endif

    // Four-phase handshake next-state logic; ack_s seen in IDLE is ignored
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (launch) state_nxt = REQ_HI;
            REQ_HI:  if (ack_s)  state_nxt = REQ_LO;
            REQ_LO:  if (!ack_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register plus registered req_out and drop outputs
    always_ff @(posedge clk_dst or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            req_out <= 1'b0;
            drop    <= 1'b0;
        end else begin
            state   <= state_nxt;
            req_out <= (state_nxt == REQ_HI);
            drop    <= drop_nxt;
        end
    end

endmodule
